// File: rtl/pwm_mixer_pkg.sv
// Shared defaults, step-direction encoding and width helper for the PWM mixer.
package pwm_mixer_pkg;

    localparam int unsigned DEF_NUM_CH          = 3;
    localparam int unsigned DEF_WIDTH           = 8;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_STEP            = 1;

    // Direction of one encoder detent, selected by the debounced B phase.
    typedef enum logic {
        STEP_UP   = 1'b0,
        STEP_DOWN = 1'b1
    } step_dir_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_mixer_n_if.sv
// Firmware load port: writes a preset value into one channel's level register.
interface pwm_mixer_n_if
    import pwm_mixer_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned WIDTH  = DEF_WIDTH
);
    localparam int unsigned CH_BITS = ch_bits(NUM_CH);

    logic               load_en;
    logic [CH_BITS-1:0] load_ch;
    logic [WIDTH-1:0]   load_val;

    modport master (output load_en, output load_ch, output load_val);
    modport slave  (input  load_en, input  load_ch, input  load_val);
endinterface

// File: rtl/pwm_mixer_n_encoder_channel.sv
// One encoder channel: pad synchronizer, per-phase debounce, detent decode
// and the saturating/wrapping level register.
module encoder_channel
    import pwm_mixer_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STEP            = DEF_STEP
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             sat_mode_i,
    input  logic             load_en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] level_o
);
    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);

    // Index 0 is phase A, index 1 is phase B.
    logic [1:0]            meta_q;
    logic [1:0]            sync_q;
    logic [1:0]            deb_q;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic                  deb_a_prev_q;
    logic [WIDTH-1:0]      level_q;
    logic [WIDTH-1:0]      level_d;
    logic                  detent;
    step_dir_e             dir;
    logic [WIDTH:0]        sum;
    logic [WIDTH:0]        diff;

    // Two-flop synchronizer; deb follows sync only after DEBOUNCE_CYCLES
    // consecutive mismatching cycles (the count reaching the limit commits).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
            deb_q  <= '0;
            cnt_q  <= '0;
        end else begin
            meta_q <= {enc_b_i, enc_a_i};
            sync_q <= meta_q;
            for (int unsigned p = 0; p < 2; p++) begin
                if (sync_q[p] == deb_q[p]) begin
                    cnt_q[p] <= '0;
                end else if (cnt_q[p] == DEB_LAST) begin
                    deb_q[p] <= sync_q[p];
                    cnt_q[p] <= '0;
                end else begin
                    cnt_q[p] <= cnt_q[p] + 1'b1;
                end
            end
        end
    end

    // Next level: a load beats a same-cycle detent; the extra top bit flags
    // overflow/underflow for saturation.
    always_comb begin
        detent  = deb_q[0] & ~deb_a_prev_q;
        dir     = deb_q[1] ? STEP_DOWN : STEP_UP;
        sum     = {1'b0, level_q} + STEP_X;
        diff    = {1'b0, level_q} - STEP_X;
        level_d = level_q;
        if (load_en_i) begin
            level_d = load_val_i;
        end else if (detent) begin
            if (dir == STEP_UP) begin
                level_d = (sat_mode_i && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            end else begin
                level_d = (sat_mode_i && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            end
        end
    end

    // Level register and previous debounced A for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_a_prev_q <= 1'b0;
            level_q      <= '0;
        end else begin
            deb_a_prev_q <= deb_q[0];
            level_q      <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/pwm_mixer_n.sv
// N-channel encoder/PWM mixer: per-channel encoder level registers feeding
// shadowed, glitch-free PWM outputs from one shared period counter.
module pwm_mixer_n
    import pwm_mixer_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STEP            = DEF_STEP
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic                    sat_mode,
    pwm_mixer_n_if.slave            ld,
    output logic [NUM_CH*WIDTH-1:0] level,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    sync,
    output logic [NUM_CH:0]         io_oeb_out,
    output logic [2*NUM_CH-1:0]     io_oeb_in
);
    localparam int unsigned CH_BITS = ch_bits(NUM_CH);

    logic [1:0]                   rst_sync_q;
    logic                         rst_n;
    logic [WIDTH-1:0]             cnt_q;
    logic [WIDTH-1:0]             cnt_d;
    logic [NUM_CH-1:0][WIDTH-1:0] active_q;
    logic [NUM_CH-1:0]            pwm_q;
    logic                         sync_q;

    // Reset asserts asynchronously everywhere but releases two clocks later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic ld_hit;
        // Indices at or beyond NUM_CH match no channel and are dropped.
        assign ld_hit = ld.load_en && (ld.load_ch == CH_BITS'(c));

        encoder_channel #(
            .WIDTH           (WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STEP            (STEP)
        ) u_ch (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .enc_a_i    (enc_a[c]),
            .enc_b_i    (enc_b[c]),
            .sat_mode_i (sat_mode),
            .load_en_i  (ld_hit),
            .load_val_i (ld.load_val),
            .level_o    (level[c*WIDTH +: WIDTH])
        );
    end

    // Free-running period counter.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    // Shadow levels are captured only at the last count of a period so a
    // period never mixes two levels; outputs are registered comparisons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= '0;
            pwm_q    <= '0;
            sync_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= (cnt_q == '0);
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (cnt_q == '1) begin
                    active_q[c] <= level[c*WIDTH +: WIDTH];
                end
                pwm_q[c] <= (cnt_q < active_q[c]);
            end
        end
    end

    assign pwm_out    = pwm_q;
    assign sync       = sync_q;
    assign io_oeb_out = '0;
    assign io_oeb_in  = '1;

endmodule

// File: tb/tb_pwm_mixer_n.sv
// Scoreboard bench for pwm_mixer_n: stimulus pushes expected levels and
// per-period duty counts; a negedge monitor pops and compares them.
module tb_pwm_mixer_n;
    import pwm_mixer_pkg::*;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEB    = 4;
    localparam int unsigned STEP   = 1;
    localparam int unsigned MAXV   = 255;
    localparam int unsigned PER    = 256;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       enc_a;
    logic [NUM_CH-1:0]       enc_b;
    logic                    sat_mode;
    logic [NUM_CH*WIDTH-1:0] level;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    sync;
    logic [NUM_CH:0]         io_oeb_out;
    logic [2*NUM_CH-1:0]     io_oeb_in;

    pwm_mixer_n_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) ld_if ();

    pwm_mixer_n #(
        .NUM_CH          (NUM_CH),
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .STEP            (STEP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .sat_mode   (sat_mode),
        .ld         (ld_if),
        .level      (level),
        .pwm_out    (pwm_out),
        .sync       (sync),
        .io_oeb_out (io_oeb_out),
        .io_oeb_in  (io_oeb_in)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        int unsigned at;
        int unsigned ch;
        int unsigned exp;
        string       name;
    } lvl_item_t;

    typedef struct {
        int unsigned per;
        int unsigned ch;
        int unsigned exp;
    } duty_item_t;

    lvl_item_t   lvl_q[$];
    duty_item_t  duty_q[$];
    int unsigned model[NUM_CH];
    int unsigned s0 = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int unsigned lvl_of(input int unsigned ch);
        return int'(level[ch*WIDTH +: WIDTH]);
    endfunction

    function automatic int unsigned off_of(input int unsigned c);
        return (c - s0) % PER;
    endfunction

    // Reference arithmetic for one detent.
    function automatic int unsigned step_model(input int unsigned l, input bit down, input bit sat);
        if (!down) return sat ? ((l + STEP > MAXV) ? MAXV : l + STEP) : (l + STEP) % PER;
        return sat ? ((l < STEP) ? 0 : l - STEP) : (l + PER - STEP) % PER;
    endfunction

    // Monitor: level expectations by cycle, sync position, duty per period.
    int unsigned hi_cnt[NUM_CH];
    int unsigned first_hi[NUM_CH];
    int unsigned last_hi[NUM_CH];
    always @(negedge clk) begin
        lvl_item_t   it;
        int unsigned off;
        int unsigned per;
        int unsigned act;
        while (lvl_q.size() > 0 && lvl_q[0].at <= cyc) begin
            it = lvl_q.pop_front();
            check(it.name, lvl_of(it.ch), it.exp);
        end
        if (mon_en && cyc >= s0) begin
            off = off_of(cyc);
            if (off == 0 || sync !== 1'b0) check("sync_pos", sync, (off == 0) ? 1 : 0);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (pwm_out[ch]) begin
                    if (hi_cnt[ch] == 0) first_hi[ch] = off;
                    last_hi[ch] = off;
                    hi_cnt[ch]++;
                end
            end
            if (off == PER - 1) begin
                per = (cyc - s0) / PER;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    // A duty that does not start at offset 0 or has gaps is reported as 9999.
                    act = (hi_cnt[ch] == 0 || (first_hi[ch] == 0 && last_hi[ch] == hi_cnt[ch] - 1))
                          ? hi_cnt[ch] : 9999;
                    for (int i = int'(duty_q.size()) - 1; i >= 0; i--) begin
                        if (duty_q[i].per == per && duty_q[i].ch == ch) begin
                            check($sformatf("duty_ch%0d_per%0d", ch, per), act, duty_q[i].exp);
                            duty_q.delete(i);
                        end
                    end
                    hi_cnt[ch] = 0;
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_lvl(input int unsigned at, input int unsigned ch, input int unsigned exp,
                            input string name);
        lvl_q.push_back('{at, ch, exp, name});
    endtask

    task automatic detent(input int unsigned ch, input bit down, input string name);
        int unsigned c0;
        enc_b[ch] = down;
        tick(8);
        enc_a[ch] = 1'b1;
        c0 = cyc;
        push_lvl(c0 + 6, ch, model[ch], {name, "_pre"});
        model[ch] = step_model(model[ch], down, sat_mode);
        push_lvl(c0 + 7, ch, model[ch], name);
        tick(8);
        enc_a[ch] = 1'b0;
        tick(8);
    endtask

    task automatic load(input int unsigned ch, input int unsigned val, input string name);
        int unsigned c;
        ld_if.load_en  = 1'b1;
        ld_if.load_ch  = 2'(ch);
        ld_if.load_val = 8'(val);
        c = cyc;
        if (ch < NUM_CH) model[ch] = val;
        for (int unsigned k = 0; k < NUM_CH; k++) push_lvl(c + 1, k, model[k], $sformatf("%s_ch%0d", name, k));
        tick(1);
        ld_if.load_en = 1'b0;
    endtask

    task automatic wait_off(input int unsigned target);
        int unsigned n = 0;
        while (off_of(cyc) != target && n < 600) begin
            tick(1);
            n++;
        end
        if (off_of(cyc) != target) check("wait_off_timeout", off_of(cyc), target);
    endtask

    initial begin
        int unsigned c0;
        int unsigned p;
        int unsigned vals[4][NUM_CH];
        reset_n        = 1'b0;
        enc_a          = '0;
        enc_b          = '0;
        sat_mode       = 1'b1;
        ld_if.load_en  = 1'b0;
        ld_if.load_ch  = '0;
        ld_if.load_val = '0;
        for (int k = 0; k < NUM_CH; k++) model[k] = 0;

        // Reset state while held.
        tick(5);
        check("rst_level", level, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_sync", sync, 0);

        // Release: first sync follows two reset-sync stages and one register.
        reset_n = 1'b1;
        s0      = cyc + 3;
        mon_en  = 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            push_lvl(s0, k, 0, $sformatf("idle_ch%0d", k));
            duty_q.push_back('{0, k, 0});
        end
        tick(4);

        // Debounce: a 3-cycle glitch is rejected, a held edge steps after 7 cycles.
        enc_a[0] = 1'b1;
        tick(3);
        enc_a[0] = 1'b0;
        tick(10);
        push_lvl(cyc + 1, 0, 0, "glitch");
        tick(2);
        detent(0, 1'b0, "deb_up");

        // Saturate vs wrap on ch1.
        load(1, 254, "ld254");
        sat_mode = 1'b1;
        for (int i = 0; i < 3; i++) detent(1, 1'b0, "sat_up");
        sat_mode = 1'b0;
        detent(1, 1'b0, "wrap_up");
        detent(1, 1'b1, "wrap_down");

        // Load and detent land in the same cycle on ch0: load wins.
        enc_b[0] = 1'b0;
        tick(8);
        enc_a[0] = 1'b1;
        c0 = cyc;
        tick(6);
        ld_if.load_en  = 1'b1;
        ld_if.load_ch  = 2'd0;
        ld_if.load_val = 8'd77;
        model[0] = 77;
        push_lvl(c0 + 7, 0, 77, "collide");
        tick(1);
        ld_if.load_en = 1'b0;
        tick(2);
        enc_a[0] = 1'b0;
        tick(8);
        push_lvl(cyc + 1, 0, 77, "collide_hold");
        tick(2);

        // Randomized detents and loads (index 3 is out of range).
        repeat (30) begin
            sat_mode = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0, 1: detent($urandom_range(0, NUM_CH - 1), 1'($urandom_range(0, 1)), "rnd_det");
                default: load($urandom_range(0, 3),
                              ($urandom_range(0, 3) == 0) ? MAXV * $urandom_range(0, 1) : $urandom_range(0, MAXV),
                              "rnd_ld");
            endcase
        end

        // PWM duty and shadowing: levels set mid-period apply from the next period.
        vals[0] = '{$urandom_range(0, MAXV), MAXV, 64};
        vals[1] = '{0, MAXV, 200};
        vals[2] = '{$urandom_range(0, MAXV), MAXV, 10};
        vals[3] = '{$urandom_range(0, MAXV), MAXV, $urandom_range(0, MAXV)};
        p = 0;
        for (int k = 0; k < 4; k++) begin
            wait_off(19);
            p = (cyc - s0) / PER;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) load(ch, vals[k][ch], "pwm_ld");
            for (int unsigned ch = 0; ch < NUM_CH; ch++) duty_q.push_back('{p + 1, ch, vals[k][ch]});
        end

        // Async reset mid-period with ch1 driving high.
        wait_off(0);
        while ((cyc - s0) / PER < p + 2 && cyc < s0 + PER * (p + 3)) tick(1);
        tick(4);
        check("pre_reset_pwm1", pwm_out[1], 1);
        check("scoreboard_drained", duty_q.size() + lvl_q.size(), 0);
        mon_en = 1'b0;
        duty_q.delete();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm_out, 0);
        check("async_rst_sync", sync, 0);
        check("async_rst_level", level, 0);
        check("oeb_out", io_oeb_out, 0);
        check("oeb_in", io_oeb_in, (1 << (2 * NUM_CH)) - 1);
        tick(3);
        reset_n = 1'b1;
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
